// File: rtl/pwm_frame_gen.sv
// Parses (address, data) byte pairs from the SPI receive path into register writes and drives a
// 256-step PWM whose duty/enable/invert settings are loaded only at period boundaries.
module pwm_frame_gen #(
  parameter int unsigned CLK_HZ         = 48_000_000,
  parameter int unsigned PWM_HZ         = 400,
  parameter int unsigned STEP_DIV       = CLK_HZ / (PWM_HZ * 256),
  parameter int unsigned TIMEOUT_CYCLES = 48_000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       pwm_out,
  output logic       period_start,
  output logic       err,
  output logic [7:0] duty_q
);

  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PreMax = PW'(STEP_DIV - 1);
  localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StAddr, StData} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    duty_sh_q, duty_sh_d;
  logic          en_sh_q, en_sh_d, inv_sh_q, inv_sh_d;
  logic          err_d;

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    step_q, step_d;
  logic [7:0]    duty_d;
  logic          en_q, en_d, inv_q, inv_d;
  logic          pre_wrap, load;
  logic          pwm_d, pstart_d;

  // Frame parser: a data byte coinciding with timeout expiry is still accepted.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    duty_sh_d = duty_sh_q;
    en_sh_d   = en_sh_q;
    inv_sh_d  = inv_sh_q;
    err_d     = 1'b0;
    unique case (state_q)
      StAddr: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          tmo_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        tmo_d = tmo_q + TW'(1);
        if (rx_valid) begin
          state_d = StAddr;
          case (addr_q)
            8'h00: duty_sh_d = rx_data;
            8'h01: begin
              en_sh_d  = rx_data[0];
              inv_sh_d = rx_data[1];
            end
            default: err_d = 1'b1;
          endcase
        end else if (tmo_q == TmoMax) begin
          state_d = StAddr;
        end
      end
    endcase
  end

  // PWM core; outputs are computed from next-state values so they align with their step.
  always_comb begin
    pre_wrap = (pre_q == PreMax);
    pre_d    = pre_wrap ? '0 : pre_q + PW'(1);
    step_d   = pre_wrap ? step_q + 8'd1 : step_q;
    load     = pre_wrap && (step_q == 8'hFF);
    duty_d   = load ? duty_sh_q : duty_q;
    en_d     = load ? en_sh_q : en_q;
    inv_d    = load ? inv_sh_q : inv_q;
    pwm_d    = en_d & ((step_d < duty_d) ^ inv_d);
    pstart_d = (pre_d == '0) && (step_d == 8'd0);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= StAddr;
      tmo_q        <= '0;
      addr_q       <= 8'h00;
      duty_sh_q    <= 8'h00;
      en_sh_q      <= 1'b1;
      inv_sh_q     <= 1'b0;
      err          <= 1'b0;
      pre_q        <= '0;
      step_q       <= 8'h00;
      duty_q       <= 8'h00;
      en_q         <= 1'b1;
      inv_q        <= 1'b0;
      pwm_out      <= 1'b0;
      // Reset state is step 0 / pre 0, so the first cycle out of reset opens a period.
      period_start <= 1'b1;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      addr_q       <= addr_d;
      duty_sh_q    <= duty_sh_d;
      en_sh_q      <= en_sh_d;
      inv_sh_q     <= inv_sh_d;
      err          <= err_d;
      pre_q        <= pre_d;
      step_q       <= step_d;
      duty_q       <= duty_d;
      en_q         <= en_d;
      inv_q        <= inv_d;
      pwm_out      <= pwm_d;
      period_start <= pstart_d;
    end
  end

endmodule

// File: tb/tb_pwm_frame_gen.sv
// Bench for pwm_frame_gen: directed frames plus random byte traffic, checked every cycle against
// a model that derives step/period from the cycle count and applies frame rules arithmetically.
module tb_pwm_frame_gen;

  localparam int StepDiv = 2;
  localparam int Tmo     = 16;
  localparam int Period  = 256 * StepDiv;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       pwm_out;
  logic       period_start;
  logic       err;
  logic [7:0] duty_q;

  pwm_frame_gen #(
    .CLK_HZ        (48_000_000),
    .PWM_HZ        (400),
    .STEP_DIV      (StepDiv),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .err         (err),
    .duty_q      (duty_q)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: n is the cycle index since reset release.
  int n;
  int m_duty, m_en, m_inv;
  int m_duty_sh, m_en_sh, m_inv_sh;
  int m_err;
  int m_pend, m_addr, m_acyc;
  int hi_cnt;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_duty = 0; m_en = 1; m_inv = 0;
    m_duty_sh = 0; m_en_sh = 1; m_inv_sh = 0;
    m_err = 0; m_pend = 0; m_addr = 0; m_acyc = 0;
    hi_cnt = 0;
  endtask

  // Called mid-cycle n: checks outputs of cycle n, presents this cycle's input, advances.
  task automatic step_cycle(input logic v, input logic [7:0] d);
    int s, exp_pwm, exp_hi, ld, nd, ne, ni;
    ld = ((n % Period) == Period - 1) ? 1 : 0;
    nd = m_duty_sh; ne = m_en_sh; ni = m_inv_sh;
    s = (n / StepDiv) % 256;
    exp_pwm = (m_en != 0) ? (((s < m_duty) ? 1 : 0) ^ m_inv) : 0;
    check_val("pwm_out", int'(pwm_out), exp_pwm);
    check_val("period_start", int'(period_start), ((n % Period) == 0) ? 1 : 0);
    check_val("duty_q", int'(duty_q), m_duty);
    check_val("err", int'(err), m_err);
    hi_cnt += int'(pwm_out);
    if (ld != 0) begin
      exp_hi = (m_en == 0) ? 0 : ((m_inv != 0) ? Period - StepDiv * m_duty : StepDiv * m_duty);
      check_val("high_count", hi_cnt, exp_hi);
      hi_cnt = 0;
    end
    rx_valid = v;
    rx_data  = d;
    m_err = 0;
    if (m_pend != 0 && (n - m_acyc) > Tmo) m_pend = 0;
    if (v) begin
      if (m_pend != 0) begin
        m_pend = 0;
        if (m_addr == 0) m_duty_sh = int'(d);
        else if (m_addr == 1) begin
          m_en_sh  = int'(d[0]);
          m_inv_sh = int'(d[1]);
        end else m_err = 1;
      end else begin
        m_pend = 1;
        m_addr = int'(d);
        m_acyc = n;
      end
    end
    @(negedge CLK);
    rx_valid = 1'b0;
    n++;
    if (ld != 0) begin
      m_duty = nd; m_en = ne; m_inv = ni;
    end
  endtask

  task automatic send(input logic [7:0] b);
    step_cycle(1'b1, b);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step_cycle(1'b0, 8'h00);
  endtask

  task automatic finish_period();
    while ((n % Period) != 0) step_cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int r, gap;
    logic [7:0] b;
    model_reset();
    do_reset();

    // Reset state and a duty write landing mid-period.
    idle(100);
    send(8'h00); send(8'h40);
    finish_period(); idle(Period);

    // Duty extremes.
    send(8'h00); send(8'hFF);
    finish_period(); idle(Period);
    send(8'h00); send(8'h00);
    finish_period(); idle(Period);

    // Control register: invert, then disabled-with-invert.
    send(8'h00); send(8'h40); send(8'h01); send(8'h03);
    finish_period(); idle(Period);
    send(8'h01); send(8'h02);
    finish_period(); idle(Period);
    send(8'h01); send(8'h01);

    // Undefined address, then a normal frame.
    send(8'h07); send(8'h55); idle(3);
    send(8'h00); send(8'h20);
    finish_period(); idle(Period);

    // Timeout just expired, then just in time.
    send(8'h00); idle(16); send(8'h80); send(8'h10); idle(5);
    send(8'h00); idle(15); send(8'h80);
    finish_period(); idle(Period);

    // Write on the load edge itself takes effect one period later.
    idle(Period - 2); send(8'h00); send(8'h30);
    idle(Period + 4);

    // Reset mid-frame: the following byte must be parsed as an address.
    send(8'h00); idle(2);
    do_reset();
    idle(7); send(8'h60); send(8'h00); send(8'h11);
    finish_period(); idle(Period);

    // Random traffic with biased addresses and mixed gaps.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 3));
      b = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : 8'($urandom_range(0, 255));
      send(b);
      gap = (($urandom_range(0, 9)) == 0) ? int'($urandom_range(14, 18))
                                          : int'($urandom_range(0, 8));
      idle(gap);
    end
    finish_period(); idle(Period);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
